imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter AW, default 5, meaning word-address width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port len  input  AW+1  number of words to load; sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port byte_valid  input  1  source has a program byte on byte_data.
REQ-009 SHALL have port byte_data  input  8  program byte.
REQ-010 SHALL have port byte_ready  output  1  controller accepts a byte this cycle.
REQ-011 SHALL have port we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port waddr  output  AW  word address being written.
REQ-013 SHALL have port wdata  output  32  assembled instruction word.
REQ-014 SHALL have port cpu_hold  output  1  holds the MIPS core (PC at 0) while high.
REQ-015 SHALL have port done  output  1  load completed; memory image valid.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-018 A byte SHALL be accepted only at a rising edge where byte_valid and byte_ready are both 1.
REQ-019 byte_ready SHALL be 1 exactly when state is LOAD; it is 0 in IDLE, FLUSH and DONE.
REQ-020 Words SHALL be assembled big-endian: first accepted byte -> wdata[31:24], fourth -> wdata[7:0].
REQ-021 On the edge accepting the 4th byte of a word, wdata SHALL be loaded with the full word and we SHALL go high for exactly one cycle.
REQ-022 waddr SHALL equal the index of the word being written: 0 for the first word, then incrementing by 1 after each we cycle.
REQ-023 A byte MAY be accepted in the same cycle we is high; wdata and waddr SHALL remain stable for the whole we cycle.
REQ-024 From IDLE or DONE, start with 1 <= len <= DEPTH SHALL capture len, clear the byte and word counters, clear done, set cpu_hold=1, and enter LOAD.
REQ-025 From IDLE or DONE, start with len=0 or len>DEPTH SHALL pulse err for one cycle and leave the state, done and cpu_hold unchanged.
REQ-026 start SHALL be ignored in LOAD and FLUSH.
REQ-027 Accepting the 4th byte of word len-1 SHALL move LOAD -> FLUSH; in FLUSH, we is high for that final word.
REQ-028 FLUSH -> DONE SHALL be unconditional after one cycle.
REQ-029 DONE SHALL have done=1 and cpu_hold=0, held until the next accepted start.
REQ-030 Latency: if the final byte is accepted at edge N, then we=1 in cycle N..N+1, and done=1 / cpu_hold=0 from edge N+1.
REQ-031 abort in LOAD SHALL return to IDLE at the next edge, discard any partial word, suppress we, and keep cpu_hold=1 and done=0.
REQ-032 An abort coinciding with acceptance of a word's 4th byte SHALL take priority: no we is issued for that word.
REQ-033 abort SHALL be ignored in IDLE, FLUSH and DONE.
REQ-034 Writes beyond index len-1 SHALL never occur; waddr SHALL never wrap within a load.

Reset
REQ-035 While rst=1, outputs SHALL be: state IDLE, byte_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0.
REQ-036 Reset asserted mid-load SHALL immediately return all state and outputs to the values in REQ-035, with no write strobe.
REQ-037 After reset release, cpu_hold SHALL stay 1 until a load completes.

Verification
REQ-038 Load len=2 with bytes 20,10,00,78,00,00,88,20 (hex), byte_valid held high -> we at waddr 0 with 32'h20100078, then at waddr 1 with 32'h00008820; FLUSH, then done=1, cpu_hold=0.
REQ-039 Apply start with len=0, then with len=33 -> one-cycle err each time; state stays IDLE, cpu_hold=1.
REQ-040 Load len=1 with byte_valid toggling every cycle -> exactly 4 bytes accepted, a single we with the correct word, done set at the edge after the final byte plus 1.
REQ-041 Raise abort after 6 bytes of a len=3 load -> one we (waddr 0), partial word dropped, IDLE, done=0; a new load then restarts at waddr 0.
REQ-042 Assert rst after 3 bytes of a load -> all outputs at reset values immediately, no we; start issued in DONE reloads with cpu_hold=1 again.
REQ-043 Load len=32 -> waddr runs 0..31 with no wrap and exactly 32 we pulses; start issued during the load is ignored.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// imem_load_ctrl_if: program-load byte stream in, instruction-memory write port and core control out
interface imem_load_ctrl_if #(parameter int AW = 5);
  logic          start;
  logic [AW:0]   len;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  modport master (
    output start, len, abort, byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata, cpu_hold, done, err
  );
  modport slave (
    input  start, len, abort, byte_valid, byte_data,
    output byte_ready, we, waddr, wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: assembles big-endian words from a byte stream and writes them into instruction memory
module imem_load_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic clk,
  input logic rst,
  imem_load_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;
  state_e        state_q, state_d;
  logic [1:0]    bc_q, bc_d;
  logic [23:0]   sh_q, sh_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   len_q, len_d;
  logic          we_q, we_d, err_q, err_d;
  logic          acc, last, len_ok, can_start;
  assign acc       = state_q == LOAD && bus.byte_valid;
  assign len_ok    = bus.len != '0 && bus.len <= (AW+1)'(DEPTH);
  assign can_start = bus.start && (state_q == IDLE || state_q == DONE);
  // waddr only advances while loading, so it still names the word being assembled
  assign last      = {1'b0, waddr_q} == len_q - (AW+1)'(1);
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    sh_d    = sh_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    len_d   = len_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    if (can_start && len_ok) begin
      len_d   = bus.len;
      bc_d    = '0;
      waddr_d = '0;
      state_d = LOAD;
    end
    err_d = can_start && !len_ok;
    if (state_q == LOAD) begin
      waddr_d = we_q ? waddr_q + AW'(1) : waddr_q;
      if (bus.abort) begin
        state_d = IDLE;
      end else if (acc) begin
        sh_d = {sh_q[15:0], bus.byte_data};
        bc_d = bc_q + 2'd1;
        if (bc_q == 2'd3) begin
          wdata_d = {sh_q, bus.byte_data};
          we_d    = 1'b1;
          state_d = last ? FLUSH : LOAD;
        end
      end
    end
    if (state_q == FLUSH) state_d = DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bc_q    <= '0;
      sh_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      len_q   <= len_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
  assign bus.byte_ready = state_q == LOAD;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.cpu_hold   = state_q != DONE;
  assign bus.done       = state_q == DONE;
  assign bus.err        = err_q;
endmodule
